// File: rtl/period_pwm_bank_pkg.sv
// Shared defaults, channel action encoding and bus-slicing helper for the
// period/decode PWM bank.
package period_pwm_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int CNT_W_DEF  = 28;

  // What a channel does on the coming clock edge, highest priority first.
  typedef enum logic [1:0] {
    ACT_SYNC  = 2'd0,
    ACT_HOLD  = 2'd1,
    ACT_WRAP  = 2'd2,
    ACT_COUNT = 2'd3
  } ch_action_e;

  typedef struct packed {
    logic cnt_clr;
    logic cnt_inc;
    logic act_load;
    logic wrap;
  } ch_ctrl_t;

  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

  function automatic ch_ctrl_t action_ctrl(input ch_action_e act);
    ch_ctrl_t c;
    c = '{cnt_clr: 1'b0, cnt_inc: 1'b0, act_load: 1'b0, wrap: 1'b0};
    case (act)
      ACT_SYNC:  c = '{cnt_clr: 1'b1, cnt_inc: 1'b0, act_load: 1'b1, wrap: 1'b0};
      ACT_HOLD:  c = '{cnt_clr: 1'b1, cnt_inc: 1'b0, act_load: 1'b1, wrap: 1'b0};
      ACT_WRAP:  c = '{cnt_clr: 1'b1, cnt_inc: 1'b0, act_load: 1'b1, wrap: 1'b1};
      ACT_COUNT: c = '{cnt_clr: 1'b0, cnt_inc: 1'b1, act_load: 1'b0, wrap: 1'b0};
      default:   c = '{cnt_clr: 1'b1, cnt_inc: 1'b0, act_load: 1'b1, wrap: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/period_pwm_bank_channel.sv
// One PWM channel: free counter, double-buffered period/duty, compare and
// registered pwm/wrap outputs.
module pwm_channel
  import period_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] decode_i,
  output logic             pwm_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_per;
  logic [CNT_W-1:0] r_act_duty;
  logic             r_pwm;
  logic             r_wrap;

  logic [CNT_W-1:0] w_per_m1;
  logic             w_running;
  logic             w_last;
  ch_action_e       w_action;
  ch_ctrl_t         w_ctrl;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_per_nxt;
  logic [CNT_W-1:0] w_duty_nxt;
  logic             w_pwm_nxt;

  assign w_per_m1  = r_act_per - ONE;
  assign w_running = enable_i & (r_act_per != ZERO);
  assign w_last    = (r_cnt == w_per_m1);

  // Sync outranks everything, so a sync landing on a wrap swallows the wrap pulse.
  always_comb begin
    w_action = ACT_HOLD;
    if (sync_i) begin
      w_action = ACT_SYNC;
    end else if (!w_running) begin
      w_action = ACT_HOLD;
    end else if (w_last) begin
      w_action = ACT_WRAP;
    end else begin
      w_action = ACT_COUNT;
    end
  end

  assign w_ctrl = action_ctrl(w_action);

  // Next counter and shadow-register values.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_per_nxt  = r_act_per;
    w_duty_nxt = r_act_duty;
    if (w_ctrl.cnt_clr) begin
      w_cnt_nxt = ZERO;
    end else if (w_ctrl.cnt_inc) begin
      w_cnt_nxt = r_cnt + ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
    if (w_ctrl.act_load) begin
      w_per_nxt  = period_i;
      w_duty_nxt = decode_i;
    end else begin
      w_per_nxt  = r_act_per;
      w_duty_nxt = r_act_duty;
    end
  end

  assign w_pwm_nxt = w_running & (r_cnt < r_act_duty);

  // Channel state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= ZERO;
      r_act_per  <= ZERO;
      r_act_duty <= ZERO;
      r_pwm      <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_act_per  <= w_per_nxt;
      r_act_duty <= w_duty_nxt;
      r_pwm      <= w_pwm_nxt;
      r_wrap     <= w_ctrl.wrap;
    end
  end

  assign pwm_o  = r_pwm;
  assign wrap_o = r_wrap;

endmodule

// File: rtl/period_pwm_bank.sv
// Multi-channel PWM/tone bank fed by packed period/decode PIO buses; each
// channel is an independent pwm_channel sharing one sync pulse.
module period_pwm_bank
  import period_pwm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH*CNT_W-1:0] decode_i,
  input  logic [NUM_CH-1:0]       enable_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic [NUM_CH-1:0]       wrap_o
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_decode;

    assign w_period = period_i[ch_lsb(k, CNT_W) +: CNT_W];
    assign w_decode = decode_i[ch_lsb(k, CNT_W) +: CNT_W];

    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .sync_i  (sync_i),
      .enable_i(enable_i[k]),
      .period_i(w_period),
      .decode_i(w_decode),
      .pwm_o   (pwm_o[k]),
      .wrap_o  (wrap_o[k])
    );
  end

endmodule

// File: tb/tb_period_pwm_bank.sv
// Directed self-checking bench for period_pwm_bank.
module tb_period_pwm_bank;

  localparam int NCH = 8;
  localparam int CW  = 28;

  logic                clk;
  logic                rst_n;
  logic [NCH*CW-1:0]   period_r;
  logic [NCH*CW-1:0]   decode_r;
  logic [NCH-1:0]      enable_r;
  logic                sync_r;
  logic [NCH-1:0]      pwm_o;
  logic [NCH-1:0]      wrap_o;

  int total;
  int bad;

  period_pwm_bank dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .period_i     (period_r),
    .decode_i     (decode_r),
    .enable_i     (enable_r),
    .sync_i       (sync_r),
    .pwm_o        (pwm_o),
    .wrap_o       (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int per, input int dec);
    period_r[k*CW +: CW] = per[CW-1:0];
    decode_r[k*CW +: CW] = dec[CW-1:0];
  endtask

  task automatic test_reset();
    logic [NCH-1:0] ep;
    logic [NCH-1:0] ew;
    rst_n = 1'b0;
    set_ch(0, 10, 3);
    set_ch(2, 4, 1);
    enable_r = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pwm_o !== 8'h00 || wrap_o !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold: pwm=%b wrap=%b required pwm=00000000 wrap=00000000", pwm_o, wrap_o);
      end
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (pwm_o !== 8'h00 || wrap_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_load: pwm=%b wrap=%b required all zero", pwm_o, wrap_o);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      ep = 8'h00; ew = 8'h00;
      ep[0] = ((k % 10) < 3);  ew[0] = ((k % 10) == 9);
      ep[2] = ((k % 4) < 1);   ew[2] = ((k % 4) == 3);
      total++;
      if (pwm_o !== ep || wrap_o !== ew) begin
        bad++;
        $display("FAIL reset_start k=%0d: pwm=%b wrap=%b required pwm=%b wrap=%b", k, pwm_o, wrap_o, ep, ew);
      end
    end
  endtask

  task automatic test_basic();
    logic [NCH-1:0] ep;
    logic [NCH-1:0] ew;
    enable_r = 8'h00;
    period_r = '0;
    decode_r = '0;
    set_ch(0, 10, 3);
    tick();
    tick();
    enable_r = 8'h01;
    for (int k = 0; k < 30; k++) begin
      tick();
      ep = 8'h00; ew = 8'h00;
      ep[0] = ((k % 10) < 3);
      ew[0] = ((k % 10) == 9);
      total++;
      if (pwm_o !== ep || wrap_o !== ew) begin
        bad++;
        $display("FAIL basic k=%0d: pwm=%b wrap=%b required pwm=%b wrap=%b", k, pwm_o, wrap_o, ep, ew);
      end
    end
  endtask

  // Continues directly from test_basic: counter index k keeps running.
  task automatic test_double_buffer();
    logic [NCH-1:0] ep;
    logic [NCH-1:0] ew;
    for (int k = 30; k < 40; k++) begin
      if (k == 35) set_ch(0, 4, 2);
      tick();
      ep = 8'h00; ew = 8'h00;
      ep[0] = ((k % 10) < 3);
      ew[0] = ((k % 10) == 9);
      total++;
      if (pwm_o !== ep || wrap_o !== ew) begin
        bad++;
        $display("FAIL dbuf_old k=%0d: pwm=%b wrap=%b required pwm=%b wrap=%b", k, pwm_o, wrap_o, ep, ew);
      end
    end
    for (int j = 0; j < 12; j++) begin
      tick();
      ep = 8'h00; ew = 8'h00;
      ep[0] = ((j % 4) < 2);
      ew[0] = ((j % 4) == 3);
      total++;
      if (pwm_o !== ep || wrap_o !== ew) begin
        bad++;
        $display("FAIL dbuf_new j=%0d: pwm=%b wrap=%b required pwm=%b wrap=%b", j, pwm_o, wrap_o, ep, ew);
      end
    end
  endtask

  task automatic run_ch0(input int per, input int dec, input int n);
    logic [NCH-1:0] ep;
    logic [NCH-1:0] ew;
    enable_r = 8'h00;
    period_r = '0;
    decode_r = '0;
    set_ch(0, per, dec);
    tick();
    tick();
    enable_r = 8'h01;
    for (int k = 0; k < n; k++) begin
      tick();
      ep = 8'h00; ew = 8'h00;
      if (per != 0) begin
        ep[0] = ((k % per) < dec);
        ew[0] = ((k % per) == per - 1);
      end
      total++;
      if (pwm_o !== ep || wrap_o !== ew) begin
        bad++;
        $display("FAIL edge per=%0d dec=%0d k=%0d: pwm=%b wrap=%b required pwm=%b wrap=%b",
                 per, dec, k, pwm_o, wrap_o, ep, ew);
      end
    end
  endtask

  task automatic test_edges();
    run_ch0(10, 0, 12);
    run_ch0(10, 10, 12);
    run_ch0(10, 15, 12);
    run_ch0(1, 0, 5);
    run_ch0(1, 1, 5);
    run_ch0(0, 5, 6);
  endtask

  task automatic test_sync();
    logic [NCH-1:0] ep;
    logic [NCH-1:0] ew;
    enable_r = 8'h00;
    period_r = '0;
    decode_r = '0;
    set_ch(0, 5, 2);
    set_ch(1, 7, 3);
    tick();
    tick();
    enable_r = 8'h03;
    for (int k = 0; k < 6; k++) begin
      tick();
      ep = 8'h00; ew = 8'h00;
      ep[0] = ((k % 5) < 2); ew[0] = ((k % 5) == 4);
      ep[1] = ((k % 7) < 3); ew[1] = ((k % 7) == 6);
      total++;
      if (pwm_o !== ep || wrap_o !== ew) begin
        bad++;
        $display("FAIL sync_pre k=%0d: pwm=%b wrap=%b required pwm=%b wrap=%b", k, pwm_o, wrap_o, ep, ew);
      end
    end
    // ch1 is at its last count here; ch0 at count 1.
    sync_r = 1'b1;
    tick();
    sync_r = 1'b0;
    total++;
    if (pwm_o !== 8'h01 || wrap_o !== 8'h00) begin
      bad++;
      $display("FAIL sync_edge: pwm=%b wrap=%b required pwm=00000001 wrap=00000000", pwm_o, wrap_o);
    end
    for (int m = 0; m < 14; m++) begin
      tick();
      ep = 8'h00; ew = 8'h00;
      ep[0] = ((m % 5) < 2); ew[0] = ((m % 5) == 4);
      ep[1] = ((m % 7) < 3); ew[1] = ((m % 7) == 6);
      total++;
      if (pwm_o !== ep || wrap_o !== ew) begin
        bad++;
        $display("FAIL sync_post m=%0d: pwm=%b wrap=%b required pwm=%b wrap=%b", m, pwm_o, wrap_o, ep, ew);
      end
    end
  endtask

  task automatic test_async_reset();
    enable_r = 8'h00;
    period_r = '0;
    decode_r = '0;
    set_ch(0, 10, 10);
    set_ch(1, 1, 1);
    tick();
    tick();
    enable_r = 8'h03;
    tick();
    tick();
    total++;
    if (pwm_o !== 8'h03 || wrap_o !== 8'h02) begin
      bad++;
      $display("FAIL async_pre: pwm=%b wrap=%b required pwm=00000011 wrap=00000010", pwm_o, wrap_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pwm_o !== 8'h00 || wrap_o !== 8'h00) begin
      bad++;
      $display("FAIL async_drop: pwm=%b wrap=%b required all zero", pwm_o, wrap_o);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    period_r = '0;
    decode_r = '0;
    enable_r = 8'h00;
    sync_r   = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_double_buffer();
    test_edges();
    test_sync();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
